// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 definitions for the fetch queue and the hazard unit.
// Contents: major opcode constants, the queue entry layout, the canonical NOP,
// and register-field extract helpers used by the pair-split rules.
package riscv_pkg;

    // Instruction word width. The entry layout is fixed to RV32.
    localparam int ILEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] get_opcode(input logic [ILEN-1:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] get_rd(input logic [ILEN-1:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [ILEN-1:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [ILEN-1:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/pair_issue_check.sv
// pair_issue_check: decides how many head-of-queue instructions issue this
// cycle (0, 1 or 2). A pair is split when both are memory ops, when H1 reads
// a register H0 writes, or when H0 is a control transfer.
// Ports:
//   i_h0_instr, i_h1_instr : instructions at the queue head (H0 older)
//   i_count                : entries currently held
//   o_issue_n              : instructions to issue
module pair_issue_check
    import riscv_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [ILEN-1:0] i_h0_instr,
    input  logic [ILEN-1:0] i_h1_instr,
    input  logic [CW-1:0]   i_count,
    output logic [1:0]      o_issue_n
);

    logic [6:0] w_op0;
    logic [6:0] w_op1;
    logic [4:0] w_rd0;
    logic       w_mem_pair;
    logic       w_h0_writes;
    logic       w_raw;
    logic       w_ctrl;
    logic       w_split;

    assign w_op0 = get_opcode(i_h0_instr);
    assign w_op1 = get_opcode(i_h1_instr);
    assign w_rd0 = get_rd(i_h0_instr);

    assign w_mem_pair  = is_mem_op(w_op0) && is_mem_op(w_op1);
    // rs2 is compared for every format; an I-type immediate that aliases rd
    // costs one split cycle, never correctness.
    assign w_h0_writes = (w_op0 != OPC_STORE) && (w_op0 != OPC_BRANCH);
    assign w_raw       = w_h0_writes && (w_rd0 != 5'd0) &&
                         ((w_rd0 == get_rs1(i_h1_instr)) || (w_rd0 == get_rs2(i_h1_instr)));
    assign w_ctrl      = (w_op0 == OPC_BRANCH) || (w_op0 == OPC_JAL) || (w_op0 == OPC_JALR);
    assign w_split     = w_mem_pair || w_raw || w_ctrl;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_issue_n = 2'd2;
        if (i_count == '0) begin
            o_issue_n = 2'd0;
        end else if ((i_count == CW'(1)) || w_split) begin
            // With one entry H1 is stale; the count test wins before split matters.
            o_issue_n = 2'd1;
        end
    end

endmodule

// File: rtl/dual_issue_fetch_queue.sv
// dual_issue_fetch_queue: buffers fetch bundles (one or two instructions) in a
// circular queue and issues up to two instructions per cycle into the slot-0 /
// slot-1 IF/ID registers, splitting pairs that cannot issue together.
// Ports:
//   fetch_valid/pc/instr0/instr1/v1 : fetch bundle; instr1 sits at pc+4
//   fetch_ready                     : room for a full bundle (current count only)
//   stall_d                         : hold IF/ID outputs, no dequeue
//   flush                           : empty queue and invalidate outputs
//   id_valid*/id_instr*/id_pc*      : issued slots, slot 0 is older
//   occupancy                       : entries held
module dual_issue_fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_valid,
    input  logic [XLEN-1:0]            fetch_pc,
    input  logic [XLEN-1:0]            fetch_instr0,
    input  logic [XLEN-1:0]            fetch_instr1,
    input  logic                       fetch_v1,
    output logic                       fetch_ready,
    input  logic                       stall_d,
    input  logic                       flush,
    output logic                       id_valid0,
    output logic                       id_valid1,
    output logic [XLEN-1:0]            id_instr0,
    output logic [XLEN-1:0]            id_instr1,
    output logic [XLEN-1:0]            id_pc0,
    output logic [XLEN-1:0]            id_pc1,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    fetch_entry_t  w_h0;
    fetch_entry_t  w_h1;
    logic          w_enq;
    logic [1:0]    w_enq_n;
    logic [1:0]    w_issue_n;
    logic [1:0]    w_deq_n;

    assign w_h0 = r_mem[r_rd_ptr];
    assign w_h1 = r_mem[r_rd_ptr + PW'(1)];

    assign fetch_ready = (CW'(DEPTH) - r_count) >= CW'(2);
    assign occupancy   = r_count;

    assign w_enq   = fetch_valid && fetch_ready && !flush;
    assign w_enq_n = w_enq ? (fetch_v1 ? 2'd2 : 2'd1) : 2'd0;
    assign w_deq_n = (flush || stall_d) ? 2'd0 : w_issue_n;

    pair_issue_check #(
        .CW (CW)
    ) u_pair_check (
        .i_h0_instr (w_h0.instr),
        .i_h1_instr (w_h1.instr),
        .i_count    (r_count),
        .o_issue_n  (w_issue_n)
    );

    // NOTE: storage has no reset; only entries below count are ever consumed,
    // so clearing the array would just add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= '{pc: fetch_pc, instr: fetch_instr0};
            if (fetch_v1) begin
                r_mem[r_wr_ptr + PW'(1)] <= '{pc: fetch_pc + XLEN'(4), instr: fetch_instr1};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_enq_n);
            r_rd_ptr <= r_rd_ptr + PW'(w_deq_n);
            r_count  <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid0 <= 1'b0;
            id_valid1 <= 1'b0;
            id_instr0 <= '0;
            id_instr1 <= '0;
            id_pc0    <= '0;
            id_pc1    <= '0;
        end else if (flush) begin
            id_valid0 <= 1'b0;
            id_valid1 <= 1'b0;
            id_instr0 <= NOP_INSTR;
            id_instr1 <= NOP_INSTR;
            id_pc0    <= '0;
            id_pc1    <= '0;
        end else if (!stall_d) begin
            id_valid0 <= (w_issue_n >= 2'd1);
            id_valid1 <= (w_issue_n == 2'd2);
            id_instr0 <= (w_issue_n >= 2'd1) ? w_h0.instr : NOP_INSTR;
            id_pc0    <= (w_issue_n >= 2'd1) ? w_h0.pc    : '0;
            id_instr1 <= (w_issue_n == 2'd2) ? w_h1.instr : NOP_INSTR;
            id_pc1    <= (w_issue_n == 2'd2) ? w_h1.pc    : '0;
        end
    end

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// tb_dual_issue_fetch_queue: directed stimulus with a scoreboard of queued
// {pc, instr} entries; a small independent model of the split rules decides
// what should issue each cycle.
module tb_dual_issue_fetch_queue;

    localparam int          DEPTH = 8;
    localparam int          XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk;
    logic              rst_n;
    logic              fetch_valid;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_instr0;
    logic [XLEN-1:0]   fetch_instr1;
    logic              fetch_v1;
    logic              fetch_ready;
    logic              stall_d;
    logic              flush;
    logic              id_valid0;
    logic              id_valid1;
    logic [XLEN-1:0]   id_instr0;
    logic [XLEN-1:0]   id_instr1;
    logic [XLEN-1:0]   id_pc0;
    logic [XLEN-1:0]   id_pc1;
    logic [3:0]        occupancy;

    dual_issue_fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_instr0 (fetch_instr0),
        .fetch_instr1 (fetch_instr1),
        .fetch_v1     (fetch_v1),
        .fetch_ready  (fetch_ready),
        .stall_d      (stall_d),
        .flush        (flush),
        .id_valid0    (id_valid0),
        .id_valid1    (id_valid1),
        .id_instr0    (id_instr0),
        .id_instr1    (id_instr1),
        .id_pc0       (id_pc0),
        .id_pc1       (id_pc1),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    logic        e_v0, e_v1;
    logic [31:0] e_i0, e_i1, e_p0, e_p1;
    bit          e_payload;
    int          n_pass;
    int          n_fail;
    int          n_total;

    // Instruction encoders
    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_beq(input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Number of instructions the queue head should issue.
    function automatic int model_n();
        logic [6:0] o0, o1;
        logic [4:0] rd0;
        bit         mem_pair, raw, ctrl;
        if (sb.size() == 0) return 0;
        if (sb.size() == 1) return 1;
        o0       = sb[0].instr[6:0];
        o1       = sb[1].instr[6:0];
        rd0      = sb[0].instr[11:7];
        mem_pair = (o0 == 7'h03 || o0 == 7'h23) && (o1 == 7'h03 || o1 == 7'h23);
        raw      = (o0 != 7'h23) && (o0 != 7'h63) && (rd0 != 5'd0) &&
                   (rd0 == sb[1].instr[19:15] || rd0 == sb[1].instr[24:20]);
        ctrl     = (o0 == 7'h63) || (o0 == 7'h6f) || (o0 == 7'h67);
        return (mem_pair || raw || ctrl) ? 1 : 2;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] i0,
                         input logic [31:0] i1, input logic v1);
        fetch_valid  = 1'b1;
        fetch_pc     = pc;
        fetch_instr0 = i0;
        fetch_instr1 = i1;
        fetch_v1     = v1;
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_v1    = 1'b0;
    endtask

    // One clock: update the model from current inputs, advance, compare.
    task automatic cycle(input string tag);
        int   n;
        bit   ready;
        ent_t a;
        ready = (sb.size() <= DEPTH - 2);
        check({tag, " fetch_ready"}, 32'(fetch_ready), 32'(ready));
        if (flush) begin
            sb.delete();
            e_v0      = 1'b0;
            e_v1      = 1'b0;
            e_payload = 1'b0;
        end else begin
            if (!stall_d) begin
                n    = model_n();
                e_v0 = (n >= 1);
                e_v1 = (n == 2);
                e_p0 = 32'h0; e_i0 = NOP;
                e_p1 = 32'h0; e_i1 = NOP;
                if (n >= 1) begin a = sb.pop_front(); e_p0 = a.pc; e_i0 = a.instr; end
                if (n == 2) begin a = sb.pop_front(); e_p1 = a.pc; e_i1 = a.instr; end
                e_payload = 1'b1;
            end
            if (fetch_valid && ready) begin
                sb.push_back('{pc: fetch_pc, instr: fetch_instr0});
                if (fetch_v1) sb.push_back('{pc: fetch_pc + 32'd4, instr: fetch_instr1});
            end
        end
        @(posedge clk);
        #1;
        check({tag, " id_valid0"}, 32'(id_valid0), 32'(e_v0));
        check({tag, " id_valid1"}, 32'(id_valid1), 32'(e_v1));
        check({tag, " occupancy"}, 32'(occupancy), 32'(sb.size()));
        if (e_payload) begin
            check({tag, " id_pc0"},    id_pc0,    e_p0);
            check({tag, " id_instr0"}, id_instr0, e_i0);
            check({tag, " id_pc1"},    id_pc1,    e_p1);
            check({tag, " id_instr1"}, id_instr1, e_i1);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " id_valid0"},   32'(id_valid0),   32'h0);
        check({tag, " id_valid1"},   32'(id_valid1),   32'h0);
        check({tag, " id_instr0"},   id_instr0,        32'h0);
        check({tag, " id_instr1"},   id_instr1,        32'h0);
        check({tag, " id_pc0"},      id_pc0,           32'h0);
        check({tag, " id_pc1"},      id_pc1,           32'h0);
        check({tag, " occupancy"},   32'(occupancy),   32'h0);
        check({tag, " fetch_ready"}, 32'(fetch_ready), 32'h1);
    endtask

    task automatic model_reset();
        sb.delete();
        e_v0 = 1'b0; e_v1 = 1'b0;
        e_i0 = 32'h0; e_i1 = 32'h0;
        e_p0 = 32'h0; e_p1 = 32'h0;
        e_payload = 1'b1;
    endtask

    initial begin
        int rd;
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        stall_d = 1'b0;
        flush   = 1'b0;
        fetch_pc = '0; fetch_instr0 = '0; fetch_instr1 = '0;
        idle();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // Basic dual issue
        drive(32'h100, enc_addi(1, 0, 1), enc_addi(2, 0, 2), 1'b1);
        cycle("basic_enq");
        idle();
        cycle("basic_issue");
        cycle("basic_empty");

        // mem+mem split
        drive(32'h200, enc_lw(5, 1, 0), enc_sw(6, 1, 4), 1'b1);
        cycle("mem_enq");
        idle();
        cycle("mem_lw");
        cycle("mem_sw");

        // RAW split, then rd=x0 dual issue
        drive(32'h300, enc_addi(3, 0, 7), enc_add(4, 3, 3), 1'b1);
        cycle("raw_enq");
        idle();
        cycle("raw_first");
        cycle("raw_second");
        drive(32'h400, enc_addi(0, 0, 7), enc_add(4, 3, 3), 1'b1);
        cycle("x0_enq");
        idle();
        cycle("x0_dual");

        // Branch in slot 0 splits
        drive(32'h600, enc_beq(1, 2), enc_addi(7, 0, 0), 1'b1);
        cycle("br_enq");
        idle();
        cycle("br_first");
        cycle("br_second");

        // Fill to DEPTH under stall, rejected bundle, drain
        stall_d = 1'b1;
        rd = 1;
        for (int i = 0; i < 4; i++) begin
            drive(32'h500 + 32'(i * 8), enc_addi(rd, 0, 0), enc_addi(rd + 1, 0, 0), 1'b1);
            rd += 2;
            cycle("fill8");
        end
        check("full8 fetch_ready", 32'(fetch_ready), 32'h0);
        drive(32'h900, enc_addi(20, 0, 0), enc_addi(21, 0, 0), 1'b1);
        cycle("full8_reject");
        idle();
        stall_d = 1'b0;
        for (int i = 0; i < 4; i++) cycle("drain8");

        // Fill to DEPTH-1, rejected bundle, drain across pointer wrap
        stall_d = 1'b1;
        rd = 1;
        for (int i = 0; i < 4; i++) begin
            drive(32'hA00 + 32'(i * 8), enc_addi(rd, 0, 0), enc_addi(rd + 1, 0, 0), (i != 3));
            rd += 2;
            cycle("fill7");
        end
        check("full7 fetch_ready", 32'(fetch_ready), 32'h0);
        drive(32'hB00, enc_addi(20, 0, 0), enc_addi(21, 0, 0), 1'b1);
        cycle("full7_reject");
        idle();
        stall_d = 1'b0;
        for (int i = 0; i < 5; i++) cycle("drain7");

        // Flush together with enqueue and dequeue
        drive(32'h700, enc_addi(1, 0, 0), enc_addi(2, 0, 0), 1'b1);
        cycle("flush_pre");
        drive(32'h800, enc_addi(3, 0, 0), enc_addi(4, 0, 0), 1'b1);
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        idle();
        cycle("flush_post");

        // Asynchronous reset mid-drain with 5 entries
        stall_d = 1'b1;
        drive(32'hC00, enc_addi(1, 0, 0), enc_addi(2, 0, 0), 1'b1);
        cycle("rst_fill");
        drive(32'hC08, enc_addi(3, 0, 0), enc_addi(4, 0, 0), 1'b1);
        cycle("rst_fill");
        drive(32'hC10, enc_addi(5, 0, 0), enc_addi(6, 0, 0), 1'b0);
        cycle("rst_fill");
        check("rst_fill occupancy5", 32'(occupancy), 32'd5);
        idle();
        stall_d = 1'b0;
        cycle("rst_drain");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_reset("rst_release");
        cycle("rst_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
